nn_frame_controller: RTL and testbench
======================================

# nn_frame_controller

Parametrised successor to the accelerator's fixed 14x14 image intake and result latch. Assembles an image from fixed-width chunks into a frame buffer, launches the digit classifier with a start/done handshake, bypasses it in test mode, and holds the classification until acknowledged. A watchdog guards against a hung classifier. Sits between the chip pins and the classifier/seg7 decoder in the top level.

## Interface
Parameters:
- IMG_W, 14, image width in pixels
- IMG_H, 14, image height in pixels
- CHUNK_W, 7, pixels per input beat; IMG_W*IMG_H must be a multiple of CHUNK_W (elaboration error otherwise)
- CLASS_W, 4, classification width (BCD)
- TIMEOUT, 1023, max classifier cycles before error; range 1..2^16-1

Derived: PIX = IMG_W*IMG_H; NCHUNK = PIX/CHUNK_W.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  begin new frame; clears chunk count
- in_valid  in  1  chunk present on in_data
- in_data  in  CHUNK_W  pixel chunk, one bit per pixel
- cls_start  out  1  one-cycle pulse launching classifier
- cls_image  out  PIX  assembled frame, stable from cls_start until HOLD exit
- cls_done  in  1  classifier result valid (sampled only in RUN)
- cls_digit  in  CLASS_W  classifier result
- result_bcd  out  CLASS_W  held classification
- result_valid  out  1  result_bcd valid (drives uo_out[7] complete flag)
- result_ack  in  1  consumer has taken result
- busy  out  1  high in LOAD and RUN
- error  out  1  high in HOLD when result came from timeout

## Operation
- States: IDLE, LOAD, RUN, HOLD.
- Reset: state IDLE, frame buffer 0, count 0, cls_start 0, result_bcd 0, result_valid 0, busy 0, error 0, watchdog 0.
- IDLE: frame_start -> LOAD, count=0, buffer cleared. in_valid ignored.
- LOAD: each in_valid beat k writes in_data to buffer bits [k*CHUNK_W +: CHUNK_W] (chunk 0 = LSBs), count++. frame_start in LOAD restarts (count=0, buffer cleared, same-cycle in_valid dropped).
- Last beat (count == NCHUNK-1 with in_valid): evaluate completed frame (including this beat):
  - value <= 9 (test mode): result_bcd = frame[CLASS_W-1:0], -> HOLD, error 0; classifier not started.
  - else: -> RUN, cls_start pulse, watchdog=0.
- RUN: cls_done -> result_bcd = cls_digit, -> HOLD, error 0. Watchdog increments each cycle; reaching TIMEOUT without cls_done -> result_bcd = all-ones (4'hF), error 1, -> HOLD. cls_done on the timeout cycle wins. frame_start, in_valid ignored.
- HOLD: result_valid 1; result_bcd/error held. result_ack -> IDLE. result_ack with frame_start same cycle -> LOAD directly. frame_start alone ignored.
- cls_done outside RUN ignored.

## Timing
- Beat accepted on same edge as in_valid; NCHUNK beats minimum, gaps allowed.
- Last beat at edge N: cls_start high for cycle N+1 only (registered), or result_valid high from N+1 in test mode.
- cls_done at edge M: result_valid high from M+1.
- Timeout: result_valid high TIMEOUT+1 cycles after cls_start cycle.
- result_ack at edge A: result_valid low from A+1.
- rst mid-operation: all state returns to reset values next edge; in-flight classifier result discarded.

## Structure
- Package nn_accel_pkg: state enum, TEST_MAX=9, ERR_DIGIT=4'hF, clog2-based count/watchdog width helpers.
- One sub-module: frame_chunk_buffer (indexed chunk write, clear, count, last-beat flag), parametrised on PIX/CHUNK_W.
- FSM, watchdog and result register in nn_frame_controller.

## Test plan
- Default params, frame_start then 28 beats forming value 0x...0007 -> no cls_start; result_bcd=7, result_valid at N+1, error 0.
- 28 beats with pixel 100 set; cls_done with digit 3 five cycles after cls_start -> result_bcd=3, result_valid next cycle; result_ack clears it next cycle.
- TIMEOUT=8, cls_done never asserted -> result_bcd=F, error 1, result_valid exactly 9 cycles after cls_start.
- frame_start after 10 beats, then 28 full beats -> buffer contains only new frame; cls_image matches.
- rst asserted in RUN, then late cls_done -> outputs all zero, state IDLE, cls_done ignored.
- IMG_W=8, IMG_H=8, CHUNK_W=16: 4 beats complete a frame; result_ack+frame_start same cycle in HOLD -> LOAD, next 4 beats accepted.

Source files
------------

// File: rtl/nn_accel_pkg.sv
// nn_accel_pkg
// Shared types and constants for the frame controller and its frame buffer.
//   state_t      : controller FSM state encoding (also exported for debug)
//   TEST_MAX     : largest frame value treated as a test-mode bypass digit
//   ERR_DIGIT    : result reported when the classifier times out (4-bit form)
//   count_width  : bits needed to count 0..n-1 (at least 1)
//   wdog_width   : bits needed to count 0..t   (at least 1)
package nn_accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int         TEST_MAX  = 9;
    localparam logic [3:0] ERR_DIGIT = 4'hF;

    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int wdog_width(input int t);
        return (t < 2) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/nn_frame_controller_if.sv
// nn_frame_controller_if
// Bundles the intake, classifier and result signals of the frame controller.
// The controller connects through the slave modport; pins/classifier/seg7
// side (or a testbench) connects through the master modport.
//
// Handshake rules:
//   intake     : a beat transfers on every rising edge where in_valid is high
//                while a frame is loading (no back-pressure; gaps allowed).
//                frame_start begins a frame and discards any partial one.
//   classifier : cls_start is a one-cycle pulse; cls_image is stable from
//                that pulse until the held result is acknowledged. cls_done
//                is a one-cycle strobe qualifying cls_digit.
//   result     : result_bcd/error are held while result_valid is high; the
//                result is consumed on the edge where result_ack is high.
//
// Parameters: CHUNK_W pixels per beat, PIX pixels per frame, CLASS_W result
// width.
interface nn_frame_controller_if #(
    parameter int CHUNK_W = 7,
    parameter int PIX     = 196,
    parameter int CLASS_W = 4
);
    logic               frame_start;
    logic               in_valid;
    logic [CHUNK_W-1:0] in_data;
    logic               cls_start;
    logic [PIX-1:0]     cls_image;
    logic               cls_done;
    logic [CLASS_W-1:0] cls_digit;
    logic [CLASS_W-1:0] result_bcd;
    logic               result_valid;
    logic               result_ack;
    logic               busy;
    logic               error;

    modport master (
        output frame_start, in_valid, in_data, cls_done, cls_digit, result_ack,
        input  cls_start, cls_image, result_bcd, result_valid, busy, error
    );

    modport slave (
        input  frame_start, in_valid, in_data, cls_done, cls_digit, result_ack,
        output cls_start, cls_image, result_bcd, result_valid, busy, error
    );
endinterface

// File: rtl/frame_chunk_buffer.sv
// frame_chunk_buffer
// Frame buffer filled one CHUNK_W-wide beat at a time, chunk 0 in the LSBs.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : empty the buffer and restart the chunk count
//   wr_en       : write wr_data into the next chunk slot
//   wr_data     : CHUNK_W pixel bits
//   frame       : registered buffer contents
//   frame_next  : buffer contents including the beat being written this cycle
//   last_beat   : the beat written this cycle completes the frame
module frame_chunk_buffer
    import nn_accel_pkg::*;
#(
    parameter int  PIX     = 196,
    parameter int  CHUNK_W = 7,
    localparam int NCHUNK  = PIX / CHUNK_W,
    localparam int CNT_W   = count_width(NCHUNK)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [CHUNK_W-1:0] wr_data,
    output logic [PIX-1:0]     frame,
    output logic [PIX-1:0]     frame_next,
    output logic               last_beat
);

    logic [CNT_W-1:0] count;

    assign last_beat = wr_en && (count == CNT_W'(NCHUNK - 1));

    // Slot decode written as a compare per chunk so the write stays a plain
    // mux per slot instead of a variable shifter.
    always_comb begin
        frame_next = frame;
        if (wr_en) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (count == CNT_W'(k)) begin
                    frame_next[k*CHUNK_W +: CHUNK_W] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            frame <= '0;
            count <= '0;
        end else if (wr_en) begin
            frame <= frame_next;
            count <= last_beat ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nn_frame_controller.sv
// nn_frame_controller
// Assembles an image from fixed-width chunks, launches the digit classifier,
// bypasses it for small test values, and holds the result until acknowledged.
// A watchdog converts a hung classifier into an error result.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : nn_frame_controller_if slave (intake, classifier, result)
//   fsm_state  : current controller state, for observation only
module nn_frame_controller
    import nn_accel_pkg::*;
#(
    parameter int  IMG_W   = 14,
    parameter int  IMG_H   = 14,
    parameter int  CHUNK_W = 7,
    parameter int  CLASS_W = 4,
    parameter int  TIMEOUT = 1023,
    localparam int PIX     = IMG_W * IMG_H,
    localparam int WD_W    = wdog_width(TIMEOUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    nn_frame_controller_if.slave bus,
    output state_t               fsm_state
);

    if ((PIX % CHUNK_W) != 0) begin : g_bad_chunk
        $error("nn_frame_controller: IMG_W*IMG_H must be a multiple of CHUNK_W");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("nn_frame_controller: TIMEOUT must be in 1..65535");
    end

    state_t             state, state_n;
    logic [WD_W-1:0]    wd;
    logic               cls_start_q;
    logic [CLASS_W-1:0] result_q;
    logic               err_q;

    logic               buf_clear, buf_wr, last_beat;
    logic [PIX-1:0]     frame, frame_next;
    logic               test_mode, timeout_hit;
    logic               busy_c, valid_c;

    frame_chunk_buffer #(
        .PIX     (PIX),
        .CHUNK_W (CHUNK_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (buf_clear),
        .wr_en      (buf_wr),
        .wr_data    (bus.in_data),
        .frame      (frame),
        .frame_next (frame_next),
        .last_beat  (last_beat)
    );

    // The bypass decision looks at the frame including the completing beat.
    assign test_mode   = (frame_next <= PIX'(TEST_MAX));
    assign timeout_hit = (wd == WD_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (bus.frame_start) state_n = ST_LOAD;
            ST_LOAD: if (last_beat) state_n = test_mode ? ST_HOLD : ST_RUN;
            // cls_done is checked first so it wins on the timeout cycle.
            ST_RUN:  if (bus.cls_done || timeout_hit) state_n = ST_HOLD;
            ST_HOLD: if (bus.result_ack) state_n = bus.frame_start ? ST_LOAD : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        buf_clear = 1'b0;
        buf_wr    = 1'b0;
        case (state)
            ST_IDLE: buf_clear = bus.frame_start;
            ST_LOAD: begin
                // A restart drops any beat arriving in the same cycle.
                buf_clear = bus.frame_start;
                buf_wr    = bus.in_valid && !bus.frame_start;
            end
            ST_HOLD: buf_clear = bus.result_ack && bus.frame_start;
            default: ;
        endcase
        busy_c  = (state == ST_LOAD) || (state == ST_RUN);
        valid_c = (state == ST_HOLD);
    end

    // Launch pulse, watchdog and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cls_start_q <= 1'b0;
            wd          <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            cls_start_q <= last_beat && !test_mode;
            if (last_beat && !test_mode) begin
                wd <= '0;
            end else if ((state == ST_RUN) && !timeout_hit) begin
                wd <= wd + WD_W'(1);
            end
            if (last_beat && test_mode) begin
                result_q <= frame_next[CLASS_W-1:0];
                err_q    <= 1'b0;
            end else if (state == ST_RUN) begin
                if (bus.cls_done) begin
                    result_q <= bus.cls_digit;
                    err_q    <= 1'b0;
                end else if (timeout_hit) begin
                    result_q <= '1;
                    err_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.cls_start    = cls_start_q;
    assign bus.cls_image    = frame;
    assign bus.result_bcd   = result_q;
    assign bus.result_valid = valid_c;
    assign bus.busy         = busy_c;
    // err_q is only meaningful while a result is held.
    assign bus.error        = err_q && (state == ST_HOLD);
    assign fsm_state        = state;

endmodule

// File: tb/tb_nn_frame_controller.sv
module tb_nn_frame_controller;
  import nn_accel_pkg::*;

  localparam int CHUNK_W = 7;
  localparam int CLASS_W = 4;
  localparam int TIMEOUT = 8;
  localparam int PIX     = 14 * 14;
  localparam int NCHUNK  = PIX / CHUNK_W;
  localparam int EW      = 32 + 1 + CLASS_W;
  localparam int B_CHUNK = 16;
  localparam int B_PIX   = 64;
  localparam int B_TO    = 30;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nn_frame_controller_if #(.CHUNK_W(CHUNK_W), .PIX(PIX), .CLASS_W(CLASS_W)) bus_a ();
  nn_frame_controller_if #(.CHUNK_W(B_CHUNK), .PIX(B_PIX), .CLASS_W(4)) bus_b ();
  state_t state_a, state_b;

  nn_frame_controller #(.IMG_W(14), .IMG_H(14), .CHUNK_W(CHUNK_W), .CLASS_W(CLASS_W), .TIMEOUT(TIMEOUT))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a), .fsm_state(state_a));
  nn_frame_controller #(.IMG_W(8), .IMG_H(8), .CHUNK_W(B_CHUNK), .CLASS_W(4), .TIMEOUT(B_TO))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b), .fsm_state(state_b));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0]  exp_q[$];      // {valid cycle, error, bcd}
  logic [PIX-1:0] exp_img_q[$];  // images expected at cls_start
  logic [4:0]     b_exp_q[$];    // {bcd, error}
  bit             rst_test = 0;
  int unsigned    next_d = 0;
  logic [3:0]     next_dg = 4'd0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frames: a mix around the test-mode boundary, single pixels, full random.
  function automatic logic [PIX-1:0] rand_img(input int kind);
    logic [PIX-1:0] v;
    v = '0;
    case (kind)
      0: v[3:0] = 4'($urandom_range(0, 15));
      1: v[$urandom_range(0, PIX-1)] = 1'b1;
      default: for (int i = 0; i < PIX; i++) v[i] = 1'($urandom_range(0, 1));
    endcase
    return v;
  endfunction

  // ---------------- drivers (DUT A) ----------------
  task automatic a_beat(input logic [CHUNK_W-1:0] d);
    for (int g = $urandom_range(0, 2); g > 0; g--) begin
      bus_a.in_valid = 1'b0;
      bus_a.in_data  = CHUNK_W'($urandom);
      @(posedge clk); #1;
    end
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
  endtask

  task automatic a_frame(input logic [PIX-1:0] img, input bit do_start);
    if (do_start) begin
      bus_a.frame_start = 1'b1;
      @(posedge clk); #1;
      bus_a.frame_start = 1'b0;
    end
    check("a_state_load", state_a, ST_LOAD);
    check("a_busy_load", bus_a.busy, 1'b1);
    for (int k = 0; k < NCHUNK; k++) a_beat(img[k*CHUNK_W +: CHUNK_W]);
    // Now just past the edge that took the last beat.
    if (img <= 9) exp_q.push_back({cyc, 1'b0, img[CLASS_W-1:0]});
    else exp_img_q.push_back(img);
  endtask

  task automatic a_wait_ack(input bit with_start);
    int n = 0;
    while (bus_a.result_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL a_result_wait: result_valid=%0b after %0d cycles, required 1", bus_a.result_valid, n);
    end
    if (!with_start && $urandom_range(0, 1) == 1) begin
      bus_a.frame_start = 1'b1;
      @(posedge clk); #1;
      bus_a.frame_start = 1'b0;
      check("a_hold_ignores_fs", state_a, ST_HOLD);
      check("a_hold_valid", bus_a.result_valid, 1'b1);
    end
    for (int w = $urandom_range(0, 3); w > 0; w--) begin
      @(posedge clk); #1;
    end
    bus_a.result_ack  = 1'b1;
    bus_a.frame_start = with_start;
    @(posedge clk); #1;
    bus_a.result_ack  = 1'b0;
    bus_a.frame_start = 1'b0;
    check("a_valid_after_ack", bus_a.result_valid, 1'b0);
    check("a_busy_after_ack", bus_a.busy, with_start);
  endtask

  // ---------------- drivers (DUT B) ----------------
  task automatic b_frame(input logic [B_PIX-1:0] img, input bit do_start);
    if (do_start) begin
      bus_b.frame_start = 1'b1;
      @(posedge clk); #1;
      bus_b.frame_start = 1'b0;
    end
    check("b_busy_load", bus_b.busy, 1'b1);
    for (int k = 0; k < B_PIX / B_CHUNK; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        bus_b.in_valid = 1'b0;
        bus_b.in_data  = B_CHUNK'($urandom);
        @(posedge clk); #1;
      end
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = img[k*B_CHUNK +: B_CHUNK];
      @(posedge clk); #1;
      bus_b.in_valid = 1'b0;
    end
    check("b_cls_image", bus_b.cls_image, img);
    b_exp_q.push_back((img <= 9) ? {img[3:0], 1'b0} : {ERR_DIGIT, 1'b1});
  endtask

  task automatic b_wait_ack(input bit with_start);
    int n = 0;
    while (bus_b.result_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL b_result_wait: result_valid=%0b after %0d cycles, required 1", bus_b.result_valid, n);
    end
    bus_b.result_ack  = 1'b1;
    bus_b.frame_start = with_start;
    @(posedge clk); #1;
    bus_b.result_ack  = 1'b0;
    bus_b.frame_start = 1'b0;
    check("b_valid_after_ack", bus_b.result_valid, 1'b0);
    check("b_state_after_ack", state_b, with_start ? ST_LOAD : ST_IDLE);
  endtask

  // ---------------- classifier model (DUT A) ----------------
  initial begin : responder
    int unsigned s, d;
    logic [CLASS_W-1:0] dg;
    bus_a.cls_done  = 1'b0;
    bus_a.cls_digit = '0;
    forever begin
      @(negedge clk);
      if (bus_a.cls_start === 1'b1) begin
        s = cyc;
        if (exp_img_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_cls_start: classifier launched with no frame needing it (cycle %0d)", cyc);
        end else begin
          check("a_cls_image", bus_a.cls_image, exp_img_q.pop_front());
        end
        if (rst_test) begin
          // Late result that must be discarded after the reset.
          repeat (6) @(negedge clk);
          bus_a.cls_digit = 4'd5;
          bus_a.cls_done  = 1'b1;
          @(negedge clk);
          bus_a.cls_done  = 1'b0;
        end else begin
          d  = (next_d != 0) ? next_d : $urandom_range(1, TIMEOUT + 4);
          dg = (next_d != 0) ? next_dg : CLASS_W'($urandom);
          next_d = 0;
          // done sampled at edge s+d; it counts up to and including the timeout edge s+TIMEOUT+1.
          if (d <= TIMEOUT + 1) exp_q.push_back({s + d, 1'b0, dg});
          else exp_q.push_back({s + TIMEOUT + 1, 1'b1, ERR_DIGIT});
          repeat (d - 1) @(negedge clk);
          bus_a.cls_digit = dg;
          bus_a.cls_done  = 1'b1;
          @(negedge clk);
          bus_a.cls_done  = 1'b0;
          bus_a.cls_digit = CLASS_W'($urandom);
        end
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin : monitor_a
    logic rv_prev, cs_prev;
    logic [EW-1:0] e;
    rv_prev = 1'b0;
    cs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rv_prev = 1'b0;
        cs_prev = 1'b0;
      end else begin
        if (bus_a.result_valid && !rv_prev) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_result: unexpected result_valid with bcd 0x%0h (cycle %0d)", bus_a.result_bcd, cyc);
          end else begin
            e = exp_q.pop_front();
            check("a_result_bcd", bus_a.result_bcd, e[CLASS_W-1:0]);
            check("a_error", bus_a.error, e[CLASS_W]);
            check("a_valid_cycle", cyc, e[EW-1:CLASS_W+1]);
            check("a_busy_hold", bus_a.busy, 1'b0);
          end
        end
        if (bus_a.cls_start) check("a_cls_start_pulse", cs_prev, 1'b0);
        rv_prev = bus_a.result_valid;
        cs_prev = bus_a.cls_start;
      end
    end
  end

  initial begin : monitor_b
    logic rv_prev;
    logic [4:0] e;
    rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rv_prev = 1'b0;
      end else begin
        if (bus_b.result_valid && !rv_prev) begin
          if (b_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_result: unexpected result_valid (cycle %0d)", cyc);
          end else begin
            e = b_exp_q.pop_front();
            check("b_result_bcd", bus_b.result_bcd, e[4:1]);
            check("b_error", bus_b.error, e[0]);
          end
        end
        rv_prev = bus_b.result_valid;
      end
    end
  end

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [PIX-1:0] img;
    bit chained, chain_next;
    bus_a.frame_start = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.result_ack = 1'b0;
    bus_b.frame_start = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.result_ack = 1'b0;
    bus_b.cls_done = 1'b0; bus_b.cls_digit = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state_a, ST_IDLE);
    check("rst_valid", bus_a.result_valid, 1'b0);
    check("rst_bcd", bus_a.result_bcd, 0);
    check("rst_busy", bus_a.busy, 1'b0);
    check("rst_error", bus_a.error, 1'b0);
    check("rst_cls_start", bus_a.cls_start, 1'b0);
    check("rst_image", bus_a.cls_image, 0);
    rst = 1'b0;

    // in_valid in IDLE is ignored
    bus_a.in_valid = 1'b1; bus_a.in_data = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
    check("idle_ignores_in", bus_a.cls_image, 0);
    check("idle_state", state_a, ST_IDLE);

    // Test-mode frame of value 7
    a_frame(PIX'(7), 1'b1);
    a_wait_ack(1'b0);

    // Pixel 100, classifier answers 3 five cycles after launch; RUN ignores intake
    img = '0; img[100] = 1'b1;
    next_d = 5; next_dg = 4'd3;
    a_frame(img, 1'b1);
    bus_a.frame_start = 1'b1; bus_a.in_valid = 1'b1; bus_a.in_data = 7'h55;
    @(posedge clk); #1;
    bus_a.frame_start = 1'b0; bus_a.in_valid = 1'b0;
    check("run_ignores_fs", state_a, ST_RUN);
    check("run_image_stable", bus_a.cls_image, img);
    a_wait_ack(1'b0);

    // Classifier never answers in time
    next_d = 20;
    a_frame(rand_img(2), 1'b1);
    a_wait_ack(1'b0);

    // Restart after 10 beats, restart beat collides with in_valid
    bus_a.frame_start = 1'b1;
    @(posedge clk); #1;
    bus_a.frame_start = 1'b0;
    for (int k = 0; k < 10; k++) a_beat(7'h7F);
    bus_a.frame_start = 1'b1; bus_a.in_valid = 1'b1; bus_a.in_data = 7'h7F;
    @(posedge clk); #1;
    bus_a.frame_start = 1'b0; bus_a.in_valid = 1'b0;
    check("restart_cleared", bus_a.cls_image, 0);
    img = rand_img(2); img[PIX-1] = 1'b1;
    a_frame(img, 1'b0);
    a_wait_ack(1'b0);

    // Boundary values around the bypass threshold
    a_frame(PIX'(9), 1'b1);  a_wait_ack(1'b0);
    a_frame(PIX'(10), 1'b1); a_wait_ack(1'b0);
    a_frame(PIX'(0), 1'b1);  a_wait_ack(1'b1);
    a_frame(PIX'(15), 1'b0); a_wait_ack(1'b0);

    // Random frames, optionally chained with ack+frame_start
    chained = 1'b0;
    for (int i = 0; i < 12; i++) begin
      a_frame(rand_img($urandom_range(0, 2)), !chained);
      chain_next = 1'($urandom_range(0, 1));
      a_wait_ack(chain_next);
      chained = chain_next;
    end

    // Reset while the classifier is running, then a late cls_done
    rst_test = 1'b1;
    img = rand_img(2); img[PIX-1] = 1'b1;
    a_frame(img, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstrun_state", state_a, ST_IDLE);
    check("rstrun_image", bus_a.cls_image, 0);
    check("rstrun_busy", bus_a.busy, 1'b0);
    check("rstrun_cls_start", bus_a.cls_start, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("late_done_state", state_a, ST_IDLE);
    check("late_done_valid", bus_a.result_valid, 1'b0);
    check("late_done_bcd", bus_a.result_bcd, 0);
    check("late_done_error", bus_a.error, 1'b0);
    rst_test = 1'b0;

    // 8x8 image, 16-pixel chunks: 4 beats per frame, chained via ack+frame_start
    b_frame(B_PIX'(5), 1'b1);
    b_wait_ack(1'b1);
    b_frame(B_PIX'(2), 1'b0);
    b_wait_ack(1'b1);
    b_frame({32'($urandom), 32'($urandom)} | 64'h100, 1'b0);
    b_wait_ack(1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("a_exp_drained", exp_q.size(), 0);
    check("a_img_drained", exp_img_q.size(), 0);
    check("b_exp_drained", b_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
